// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - shared register offsets, FSM encoding and CAUSE layout
package irq_controller_pkg;

  localparam logic [1:0] OFF_IE    = 2'd0;
  localparam logic [1:0] OFF_IP    = 2'd1;
  localparam logic [1:0] OFF_CAUSE = 2'd2;
  localparam logic [1:0] OFF_CTRL  = 2'd3;

  localparam int CAUSE_VALID_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
module irq_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic [2:0]      id,
  output logic            any
);

  always_comb begin
    id  = 3'd0;
    any = |req;
    // Scan high to low so the lowest active index is the last assignment.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - memory-mapped edge-triggered interrupt controller for the CPU IRQ line
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          NSRC = 4,
  parameter logic [31:0] BASE = 32'h4000_0030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRd,
  input  logic            MemWr,
  input  logic [31:0]     Addr,
  input  logic [31:0]     WriteData,
  output logic [31:0]     ReadData,
  input  logic [NSRC-1:0] src,
  input  logic            kernel,
  output logic            IRQ
);

  logic [NSRC-1:0] ie, pending, src_d, rise, active, w1c, entry_clr;
  logic            gie, cause_valid, irq_q, any_active, sel, wr;
  logic [2:0]      cause_id, winner;
  irq_state_t      state;
  logic            unused_bits;

  assign sel    = (Addr[31:4] == BASE[31:4]);
  assign wr     = MemWr & sel;
  assign rise   = src & ~src_d;
  assign active = pending & ie;
  assign w1c    = (wr && Addr[3:2] == OFF_IP) ? WriteData[NSRC-1:0] : '0;
  assign IRQ    = irq_q;
  assign unused_bits = ^{Addr[1:0], WriteData};

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .req (active),
    .id  (winner),
    .any (any_active)
  );

  always_comb begin
    entry_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      entry_clr[i] = (state == ST_REQ) && kernel && (winner == 3'(i));
    end
  end

  // Rise is OR'd in last so a same-cycle edge beats any clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_d   <= '0;
      pending <= '0;
      ie      <= '0;
      gie     <= 1'b0;
    end else begin
      src_d   <= src;
      pending <= (pending & ~w1c & ~entry_clr) | rise;
      if (wr && Addr[3:2] == OFF_IE)   ie  <= WriteData[NSRC-1:0];
      if (wr && Addr[3:2] == OFF_CTRL) gie <= WriteData[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      irq_q       <= 1'b0;
      cause_valid <= 1'b0;
      cause_id    <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          irq_q <= 1'b0;
          if (gie && any_active && !kernel) begin
            state <= ST_REQ;
            irq_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (kernel) begin
            state       <= ST_SERVICE;
            irq_q       <= 1'b0;
            cause_valid <= 1'b1;
            cause_id    <= winner;
          end else if (!any_active || !gie) begin
            state <= ST_IDLE;
            irq_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          irq_q <= 1'b0;
          if (!kernel) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          irq_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (MemRd && sel) begin
      case (Addr[3:2])
        OFF_IE:    ReadData[NSRC-1:0] = ie;
        OFF_IP:    ReadData[NSRC-1:0] = pending;
        OFF_CAUSE: begin
          ReadData[CAUSE_VALID_BIT] = cause_valid;
          ReadData[2:0]             = cause_id;
        end
        OFF_CTRL:  ReadData[0] = gie;
        default:   ReadData = 32'h0;
      endcase
    end
  end

endmodule
